// File: rtl/board_if.sv
// board_if: controller-to-board-engine bundle of strobes, load data and status outputs
//   master: controller side (drives inp/count/strobes, observes status and dump)
//   slave : engine side (observes strobes, drives wai/lose_sig/dout/dvalid/gen)
interface board_if #(parameter int GW = 8);
  logic          inp;
  logic [8:0]    count;
  logic          load_data;
  logic          read_data;
  logic          write_data;
  logic          write_out;
  logic          restart;
  logic          wai;
  logic          lose_sig;
  logic          dout;
  logic          dvalid;
  logic [GW-1:0] gen;
  modport master (
    output inp, count, load_data, read_data, write_data, write_out, restart,
    input  wai, lose_sig, dout, dvalid, gen
  );
  modport slave (
    input  inp, count, load_data, read_data, write_data, write_out, restart,
    output wai, lose_sig, dout, dvalid, gen
  );
endinterface

// File: rtl/board_engine.sv
// board_engine: rule-90 1-D board (wrap-around) with shadow sweep, commit and serial dump
//   clka  : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : board_if.slave -- strobes/load inputs in; wai, lose_sig, dout, dvalid, gen out
module board_engine #(
  parameter int CELLS = 256,
  parameter int GW    = 8
) (
  input  logic clka,
  input  logic reset,
  board_if.slave bus
);
  localparam int IW = $clog2(CELLS);
  localparam logic [IW-1:0] LAST = IW'(CELLS - 1);
  localparam logic [9:0] NC = 10'(CELLS);
  typedef enum logic [1:0] {IDLE, SWEEP, COMMIT, DUMP} state_t;
  state_t state, state_n;
  logic [CELLS-1:0] board, shadow;
  logic [IW-1:0] idx, idx_n, prv, nxt;
  logic wai, lose_sig, dout, dvalid;
  logic [GW-1:0] gen;
  logic do_load;
  assign prv = (idx == '0) ? LAST : idx - 1'b1;
  assign nxt = (idx == LAST) ? '0 : idx + 1'b1;
  // loadData is the lowest-priority IDLE strobe; out-of-range indices are dropped
  assign do_load = (state == IDLE) && bus.load_data && !bus.write_data && !bus.read_data &&
                   !bus.write_out && ({1'b0, bus.count} < NC);
  always_comb begin
    state_n = state;
    idx_n = '0;
    case (state)
      IDLE: state_n = bus.write_data ? COMMIT : bus.read_data ? SWEEP : bus.write_out ? DUMP : IDLE;
      SWEEP, DUMP: begin
        state_n = (idx == LAST) ? IDLE : state;
        idx_n = nxt;
      end
      default: state_n = IDLE;
    endcase
    if (bus.restart) begin
      state_n = IDLE;
      idx_n = '0;
    end
  end
  always_ff @(posedge clka or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // status outputs are registered from the next-state so they line up with the state they describe
  always_ff @(posedge clka or posedge reset)
    if (reset) begin
      board <= '0;
      shadow <= '0;
      idx <= '0;
      wai <= 1'b0;
      lose_sig <= 1'b0;
      dout <= 1'b0;
      dvalid <= 1'b0;
      gen <= '0;
    end else begin
      idx <= idx_n;
      wai <= (state_n != IDLE);
      dvalid <= (state_n == DUMP);
      dout <= (state_n == DUMP) & board[idx_n];
      if (bus.restart) begin
        board <= '0;
        shadow <= '0;
        gen <= '0;
        lose_sig <= 1'b0;
      end else begin
        if (state == SWEEP) shadow[idx] <= board[prv] ^ board[nxt];
        if (state == COMMIT) begin
          board <= shadow;
          gen <= gen + 1'b1;
          lose_sig <= ~|shadow;
        end
        if (do_load) board[bus.count[IW-1:0]] <= bus.inp;
      end
    end
  assign bus.wai = wai;
  assign bus.lose_sig = lose_sig;
  assign bus.dout = dout;
  assign bus.dvalid = dvalid;
  assign bus.gen = gen;
endmodule
